// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decodes a B-type branch, evaluates its condition and target, flags illegal/misaligned.
// Latency: 1 cycle from input accept to out_valid, with full throughput while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; a held result keeps every out_* stable.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_target,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic              out_illegal,
`ifdef BRANCH_STATS_EN
  output logic              out_misaligned,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken
`else
  output logic              out_misaligned
`endif
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  // Low target bits that must be zero: 2-byte alignment checks bit 0, 4-byte checks bits 1:0.
  localparam logic [1:0] ALIGN_MASK = (IALIGN == 16) ? 2'b01 : 2'b11;

  logic              out_valid_q,  out_valid_d;
  logic              taken_q,      taken_d;
  logic [XLEN-1:0]   target_q,     target_d;
  logic [4:0]        rs1_q,        rs1_d;
  logic [4:0]        rs2_q,        rs2_d;
  logic [2:0]        funct3_q,     funct3_d;
  logic              illegal_q,    illegal_d;
  logic              misaligned_q, misaligned_d;

  logic              accept;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [12:0]       imm13;
  logic [XLEN-1:0]   imm_ext;
  logic [XLEN-1:0]   target;
  logic              illegal;
  logic              cond;
  logic              taken;
  logic              misaligned;

  // Decode the instruction and resolve condition, target and alignment for the incoming branch.
  always_comb begin
    opcode     = instruction[6:0];
    funct3     = instruction[14:12];
    imm13      = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    imm_ext    = {{(XLEN-13){imm13[12]}}, imm13};
    target     = pc + imm_ext;
    illegal    = (opcode != OPC_BRANCH) || (funct3 == 3'b010) || (funct3 == 3'b011);
    cond       = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
    taken      = !illegal && cond;
    misaligned = taken && (|(target[1:0] & ALIGN_MASK));
  end

  // Handshake: reset keeps in_ready high so upstream never sees a stall while the pipe is flushed.
  always_comb begin
    in_ready = rst || !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  // Output stage next state: load on accept, otherwise hold; valid clears once drained.
  always_comb begin
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    funct3_d     = funct3_q;
    illegal_d    = illegal_q;
    misaligned_d = misaligned_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      taken_d      = taken;
      target_d     = target;
      rs1_d        = instruction[19:15];
      rs2_d        = instruction[24:20];
      funct3_d     = funct3;
      illegal_d    = illegal;
      misaligned_d = misaligned;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output register; reset drops any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      funct3_q     <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      funct3_q     <= funct3_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_funct3     = funct3_q;
  assign out_illegal    = illegal_q;
  assign out_misaligned = misaligned_q;

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] branches_q, branches_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             retire;

  // Count legal branches leaving through the output handshake, saturating at all-ones.
  always_comb begin
    retire      = out_valid_q && out_ready && !illegal_q;
    branches_d  = branches_q;
    taken_cnt_d = taken_cnt_q;
    if (retire) begin
      if (branches_q != CNT_MAX) begin
        branches_d = branches_q + CNT_W'(1);
      end
      if (taken_q && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      branches_q  <= branches_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign stat_branches = branches_q;
  assign stat_taken    = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations for decode, conditions,
// target wrap, alignment, backpressure, illegal handling and reset of a held result.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic        out_illegal;
  logic        out_misaligned;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int hs_base;

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction    (instruction),
    .pc             (pc),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_funct3     (out_funct3),
    .out_illegal    (out_illegal),
`ifdef BRANCH_STATS_EN
    .out_misaligned (out_misaligned),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
`else
    .out_misaligned (out_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshakes seen at each rising edge.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // B-type encoding with rs1=x1, rs2=x2.
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Present one transaction for one edge, then drop in_valid 1ns after that edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    instruction = ins;
    pc          = p;
    rs1_data    = a;
    rs2_data    = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_target", out_target, 0);
    check_eq("rst_taken", out_taken, 0);

    // 1: BEQ pc=0x100 imm=+8, equal operands
    check_eq("beq_in_ready", in_ready, 1);
    issue(enc_b(13'd8, 3'b000), 32'h100, 32'd5, 32'd5);
    check_eq("beq_valid", out_valid, 1);
    check_eq("beq_taken", out_taken, 1);
    check_eq("beq_target", out_target, 32'h108);
    check_eq("beq_illegal", out_illegal, 0);
    check_eq("beq_rs1", out_rs1, 1);
    check_eq("beq_rs2", out_rs2, 2);
    check_eq("beq_funct3", out_funct3, 0);

    // 2: back-to-back condition checks, each result read the cycle it is valid
    issue(enc_b(13'd8, 3'b100), 32'h100, 32'hFFFFFFFF, 32'd1);
    check_eq("blt_taken", out_taken, 1);
    issue(enc_b(13'd8, 3'b110), 32'h100, 32'hFFFFFFFF, 32'd1);
    check_eq("bltu_taken", out_taken, 0);
    check_eq("bltu_funct3", out_funct3, 3'b110);
    issue(enc_b(13'd8, 3'b101), 32'h100, 32'hFFFFFFFF, 32'd1);
    check_eq("bge_taken", out_taken, 0);
    issue(enc_b(13'd8, 3'b111), 32'h100, 32'hFFFFFFFF, 32'd1);
    check_eq("bgeu_taken", out_taken, 1);
    issue(enc_b(13'd8, 3'b001), 32'h100, 32'd5, 32'd5);
    check_eq("bne_taken", out_taken, 0);

    // 3: target wrap and alignment
    issue(enc_b(13'h1FFC, 3'b000), 32'h0, 32'd7, 32'd7);
    check_eq("wrap_target", out_target, 32'hFFFFFFFC);
    check_eq("wrap_misal", out_misaligned, 0);
    issue(enc_b(13'd2, 3'b000), 32'h0, 32'd7, 32'd7);
    check_eq("mis_target", out_target, 32'h2);
    check_eq("mis_taken", out_misaligned, 1);
    issue(enc_b(13'd2, 3'b001), 32'h0, 32'd7, 32'd7);
    check_eq("mis_nottaken", out_misaligned, 0);
    @(posedge clk); #1;
    check_eq("drain_valid", out_valid, 0);

    // 4: backpressure, held result A then B arriving when the stall lifts
    out_ready = 1'b0;
    issue(enc_b(13'h10, 3'b000), 32'h200, 32'd3, 32'd3);
    hs_base = hs_cnt;
    instruction = enc_b(13'h1FF8, 3'b001);
    pc = 32'h300; rs1_data = 32'd1; rs2_data = 32'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_target", out_target, 32'h210);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_b_valid", out_valid, 1);
    check_eq("bp_b_target", out_target, 32'h2F8);
    check_eq("bp_b_taken", out_taken, 1);
    @(posedge clk); #1;
    check_eq("bp_empty", out_valid, 0);
    check_eq("bp_hs_count", hs_cnt - hs_base, 2);

    // 5: illegal funct3 and non-branch opcode
    issue(enc_b(13'd2, 3'b010), 32'h10, 32'd4, 32'd4);
    check_eq("ill_f3", out_illegal, 1);
    check_eq("ill_f3_taken", out_taken, 0);
    check_eq("ill_f3_misal", out_misaligned, 0);
    check_eq("ill_f3_target", out_target, 32'h12);
    issue(32'h002081B3, 32'h10, 32'd4, 32'd4);
    check_eq("ill_opc", out_illegal, 1);
    check_eq("ill_opc_taken", out_taken, 0);
    @(posedge clk); #1;
`ifdef BRANCH_STATS_EN
    check_eq("stat_branches", stat_branches, 11);
    check_eq("stat_taken", stat_taken, 7);
`endif

    // 6: reset while a result is held
    out_ready = 1'b0;
    issue(enc_b(13'd8, 3'b000), 32'h400, 32'd1, 32'd1);
    check_eq("hold_valid", out_valid, 1);
    check_eq("hold_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check_eq("rst_hold_rdy", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst2_valid", out_valid, 0);
    check_eq("rst2_taken", out_taken, 0);
    check_eq("rst2_target", out_target, 0);
    check_eq("rst2_in_ready", in_ready, 1);
`ifdef BRANCH_STATS_EN
    check_eq("rst2_stat_br", stat_branches, 0);
    check_eq("rst2_stat_tk", stat_taken, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
